// File: rtl/swarb.sv
// swarb: per-output-port switch arbiter.
//
// Grants one output port to one of PORT_N input channels. Selection is
// round-robin from a rotating pointer. The grant is held for the whole packet
// until the owning channel signals its tail flit. A packet counter and a
// stuck-owner watchdog are provided for debug.
//
// Ports:
//   clk        clock
//   rst        synchronous reset, active-high
//   req_i      per-channel request
//   port_i     per-channel requested output index, slice k = channel k
//   tail_i     per-channel tail/headtail flit transfer this cycle
//   dst_rdy_i  downstream buffer of this output can accept a flit
//   grt_o      one-hot grant (registered)
//   busy_o     output currently owned
//   owner_o    index of current or last owner
//   pkt_cnt_o  packets granted since reset, wraps
//   err_o      sticky watchdog error
module swarb #(
    parameter int unsigned PORT_N   = 5,
    parameter int unsigned PORT_W   = 3,
    parameter int unsigned OUTID    = 0,
    parameter int unsigned HOLD_MAX = 256
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [PORT_N-1:0]        req_i,
    input  logic [PORT_N*PORT_W-1:0] port_i,
    input  logic [PORT_N-1:0]        tail_i,
    input  logic                     dst_rdy_i,
    output logic [PORT_N-1:0]        grt_o,
    output logic                     busy_o,
    output logic [PORT_W-1:0]        owner_o,
    output logic [15:0]              pkt_cnt_o,
    output logic                     err_o
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;
    localparam int unsigned CNT_W = $clog2(HOLD_MAX + 1);

    logic [0:0]        state_q, state_d;
    logic [PORT_N-1:0] grt_q, grt_d;
    logic [PORT_W-1:0] owner_q, owner_d;
    logic [PORT_W-1:0] ptr_q, ptr_d;
    logic [15:0]       pkt_cnt_q, pkt_cnt_d;
    logic [CNT_W-1:0]  hold_cnt_q, hold_cnt_d;
    logic              err_q, err_d;

    logic [PORT_N-1:0] elig;
    logic              win_vld;
    logic [PORT_W-1:0] win;
    logic              owner_tail;

    always_comb begin
        for (int k = 0; k < int'(PORT_N); k++) begin
            elig[k] = req_i[k] && (port_i[k*PORT_W +: PORT_W] == PORT_W'(OUTID));
        end
    end

    // First eligible channel searching ptr, ptr+1, ... with wrap.
    always_comb begin
        int unsigned idx;
        idx     = 0;
        win_vld = 1'b0;
        win     = '0;
        for (int i = 0; i < int'(PORT_N); i++) begin
            idx = (32'(ptr_q) + 32'(i)) % PORT_N;
            if (!win_vld && elig[idx]) begin
                win_vld = 1'b1;
                win     = PORT_W'(idx);
            end
        end
    end

    assign owner_tail = tail_i[owner_q];

    always_comb begin
        state_d    = state_q;
        grt_d      = grt_q;
        owner_d    = owner_q;
        ptr_d      = ptr_q;
        pkt_cnt_d  = pkt_cnt_q;
        hold_cnt_d = hold_cnt_q;
        err_d      = err_q;
        case (state_q)
            ST_IDLE: begin
                grt_d = '0;
                if (win_vld && dst_rdy_i) begin
                    state_d    = ST_HOLD;
                    grt_d[win] = 1'b1;
                    owner_d    = win;
                    ptr_d      = (win == PORT_W'(PORT_N - 1)) ? '0 : win + PORT_W'(1);
                    pkt_cnt_d  = pkt_cnt_q + 16'd1;
                    hold_cnt_d = '0;
                end
            end
            ST_HOLD: begin
                // Grant is tied to the channel; req_i, port_i and dst_rdy_i are ignored here.
                if (owner_tail) begin
                    state_d = ST_IDLE;
                    grt_d   = '0;
                end else if (hold_cnt_q != CNT_W'(HOLD_MAX)) begin
                    hold_cnt_d = hold_cnt_q + CNT_W'(1);
                    if (hold_cnt_q == CNT_W'(HOLD_MAX - 1)) begin
                        err_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                grt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            grt_q      <= '0;
            owner_q    <= '0;
            ptr_q      <= '0;
            pkt_cnt_q  <= '0;
            hold_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            grt_q      <= grt_d;
            owner_q    <= owner_d;
            ptr_q      <= ptr_d;
            pkt_cnt_q  <= pkt_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            err_q      <= err_d;
        end
    end

    assign grt_o     = grt_q;
    assign busy_o    = (state_q == ST_HOLD);
    assign owner_o   = owner_q;
    assign pkt_cnt_o = pkt_cnt_q;
    assign err_o     = err_q;

endmodule
